// File: rtl/keyboard_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_pkg
// Shared definitions for the Apple-1 keyboard input block: PS/2 scancodes,
// Apple-1 ASCII constants, the PS/2 receiver state type and a letter test.
// -----------------------------------------------------------------------------
package keyboard_pkg;

  // PS/2 set-2 scancodes with special meaning to the decoder
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_F12    = 8'h07;

  // Apple-1 7-bit ASCII
  localparam logic [6:0] CR     = 7'h0D;
  localparam logic [6:0] RUBOUT = 7'h5F;  // Apple-1 uses '_' as rubout
  localparam logic [6:0] ESC    = 7'h1B;
  localparam logic [6:0] SPACE  = 7'h20;
  localparam logic [6:0] NO_KEY = 7'h00;  // translation result for unmapped codes

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic logic is_letter(input logic [6:0] a);
    return (a >= 7'h41) && (a <= 7'h5A);
  endfunction

endpackage

// File: rtl/keyboard_if.sv
// -----------------------------------------------------------------------------
// keyboard_if
// CPU-side PIA port A register bus of the keyboard block.
//   cpu_clken : CPU clock enable qualifying reads
//   address   : 0 = KBD, 1 = KBDCR
//   r_en      : read strobe
//   dout      : register read data (combinational from the slave)
// -----------------------------------------------------------------------------
interface keyboard_if;
  logic       cpu_clken;
  logic       address;
  logic       r_en;
  logic [7:0] dout;

  modport master (output cpu_clken, output address, output r_en, input dout);
  modport slave  (input cpu_clken, input address, input r_en, output dout);
endinterface

// File: rtl/keyboard_ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 frame receiver: synchronizes the raw PS/2 lines, detects clock falling
// edges, collects start/8 data/parity/stop bits and flags good frames.
//   sys_clock, reset : system clock, async active-high reset
//   ps2_clk_i        : raw PS/2 clock (asynchronous)
//   ps2_data_i       : raw PS/2 data (asynchronous)
//   code_o           : received scancode, valid with code_valid_o
//   code_valid_o     : one-cycle pulse per frame with good parity and stop bit
// -----------------------------------------------------------------------------
module ps2_rx
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 28636,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       code_valid_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        code_valid_q, code_valid_d;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Synchronizers reset to the idle-high bus level so leaving reset never
  // looks like a falling edge.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timer_q      <= timer_d;
      code_valid_q <= code_valid_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    timer_d      = timer_q;
    code_valid_d = 1'b0;

    if (fall) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!data_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = data_s;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          code_valid_d = data_s & (^{shift_q, parity_q});
          state_d      = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end

    // Watchdog on partial frames: restarted by each edge, idle while IDLE.
    if (state_q == RX_IDLE || fall) begin
      timer_d = '0;
    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      timer_d = '0;
      state_d = RX_IDLE;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign code_o       = shift_q;
  assign code_valid_o = code_valid_q;

endmodule

// File: rtl/keyboard.sv
// -----------------------------------------------------------------------------
// keyboard
// Apple-1 keyboard input: PS/2 make/break decoding to 7-bit uppercase ASCII,
// presented as the PIA KBD/KBDCR register pair, plus front-panel keys.
//   sys_clock, reset : system clock, async active-high reset
//   ps2_clk/ps2_data : raw PS/2 lines
//   bus (slave)      : cpu_clken, address, r_en in; dout out
//   reset_key        : one-cycle pulse on F12 make
//   clr_screen       : high while F1 is held
// -----------------------------------------------------------------------------
module keyboard
  import keyboard_pkg::*;
#(
  parameter int timeout_cycles = 28636,
  parameter int sync_stages    = 2
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  keyboard_if.slave  bus,
  output logic       reset_key,
  output logic       clr_screen
);

  logic [7:0] code;
  logic       code_valid;

  ps2_rx #(
    .TIMEOUT_CYCLES (timeout_cycles),
    .SYNC_STAGES    (sync_stages)
  ) u_rx (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .code_o       (code),
    .code_valid_o (code_valid)
  );

  // US-layout set-2 translation; NO_KEY marks unmapped codes.
  function automatic logic [6:0] scan_to_ascii(input logic [7:0] sc, input logic shift);
    logic [6:0] a;
    a = NO_KEY;
    case (sc)
      8'h1C: a = 7'h41;  8'h32: a = 7'h42;  8'h21: a = 7'h43;  8'h23: a = 7'h44;
      8'h24: a = 7'h45;  8'h2B: a = 7'h46;  8'h34: a = 7'h47;  8'h33: a = 7'h48;
      8'h43: a = 7'h49;  8'h3B: a = 7'h4A;  8'h42: a = 7'h4B;  8'h4B: a = 7'h4C;
      8'h3A: a = 7'h4D;  8'h31: a = 7'h4E;  8'h44: a = 7'h4F;  8'h4D: a = 7'h50;
      8'h15: a = 7'h51;  8'h2D: a = 7'h52;  8'h1B: a = 7'h53;  8'h2C: a = 7'h54;
      8'h3C: a = 7'h55;  8'h2A: a = 7'h56;  8'h1D: a = 7'h57;  8'h22: a = 7'h58;
      8'h35: a = 7'h59;  8'h1A: a = 7'h5A;
      8'h45: a = shift ? 7'h29 : 7'h30;
      8'h16: a = shift ? 7'h21 : 7'h31;
      8'h1E: a = shift ? 7'h40 : 7'h32;
      8'h26: a = shift ? 7'h23 : 7'h33;
      8'h25: a = shift ? 7'h24 : 7'h34;
      8'h2E: a = shift ? 7'h25 : 7'h35;
      8'h36: a = shift ? 7'h5E : 7'h36;
      8'h3D: a = shift ? 7'h26 : 7'h37;
      8'h3E: a = shift ? 7'h2A : 7'h38;
      8'h46: a = shift ? 7'h28 : 7'h39;
      8'h4E: a = shift ? 7'h5F : 7'h2D;
      8'h55: a = shift ? 7'h2B : 7'h3D;
      8'h54: a = shift ? 7'h7B : 7'h5B;
      8'h5B: a = shift ? 7'h7D : 7'h5D;
      8'h5D: a = shift ? 7'h7C : 7'h5C;
      8'h4C: a = shift ? 7'h3A : 7'h3B;
      8'h52: a = shift ? 7'h22 : 7'h27;
      8'h41: a = shift ? 7'h3C : 7'h2C;
      8'h49: a = shift ? 7'h3E : 7'h2E;
      8'h4A: a = shift ? 7'h3F : 7'h2F;
      8'h0E: a = shift ? 7'h7E : 7'h60;
      SC_ENTER: a = CR;
      SC_BKSP:  a = RUBOUT;
      SC_ESC:   a = ESC;
      SC_SPACE: a = SPACE;
      default:  a = NO_KEY;
    endcase
    return a;
  endfunction

  logic       strobe_q, strobe_d;
  logic [6:0] key_q, key_d;
  logic       shift_q, shift_d, ctrl_q, ctrl_d;
  logic       brk_q, brk_d, clr_q, clr_d;
  logic       reset_key_q, reset_key_d;
  logic [6:0] ascii, char_ascii;
  logic       new_char, read_kbd;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      strobe_q    <= 1'b0;
      key_q       <= '0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      brk_q       <= 1'b0;
      clr_q       <= 1'b0;
      reset_key_q <= 1'b0;
    end else begin
      strobe_q    <= strobe_d;
      key_q       <= key_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      brk_q       <= brk_d;
      clr_q       <= clr_d;
      reset_key_q <= reset_key_d;
    end
  end

  always_comb begin
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    brk_d       = brk_q;
    clr_d       = clr_q;
    reset_key_d = 1'b0;
    new_char    = 1'b0;
    ascii       = scan_to_ascii(code, shift_q);
    char_ascii  = (ctrl_q && is_letter(ascii)) ? (ascii & 7'h1F) : ascii;

    // The E0 prefix carries no meaning for this keyboard and is skipped.
    if (code_valid && code != SC_EXT) begin
      if (code == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        case (code)
          SC_LSHIFT, SC_RSHIFT: shift_d = 1'b0;
          SC_CTRL:              ctrl_d  = 1'b0;
          SC_F1:                clr_d   = 1'b0;
          default: ;
        endcase
      end else begin
        case (code)
          SC_LSHIFT, SC_RSHIFT: shift_d     = 1'b1;
          SC_CTRL:              ctrl_d      = 1'b1;
          SC_F1:                clr_d       = 1'b1;
          SC_F12:               reset_key_d = 1'b1;
          default:              new_char    = (ascii != NO_KEY);
        endcase
      end
    end

    // A new character outranks a simultaneous clearing read of KBD.
    read_kbd = bus.cpu_clken & bus.r_en & ~bus.address;
    strobe_d = new_char ? 1'b1 : (read_kbd ? 1'b0 : strobe_q);
    key_d    = new_char ? char_ascii : key_q;
  end

  assign bus.dout   = bus.address ? {strobe_q, 7'b0} : {strobe_q, key_q};
  assign reset_key  = reset_key_q;
  assign clr_screen = clr_q;

endmodule

// File: tb/tb_keyboard.sv
// -----------------------------------------------------------------------------
// tb_keyboard
// Directed PS/2 frames against keyboard, checked by a keystroke-level model
// (table lookup of the US layout plus modifier flags) and literal expectations.
// -----------------------------------------------------------------------------
module tb_keyboard;

  localparam int TIMEOUT = 28636;
  localparam int HALF    = 8;     // sys_clock cycles per PS/2 clock half-period

  logic sys_clock = 1'b0;
  logic reset     = 1'b1;
  logic ps2_clk   = 1'b1;
  logic ps2_data  = 1'b1;
  logic reset_key, clr_screen;

  keyboard_if bus ();

  keyboard #(
    .timeout_cycles (TIMEOUT),
    .sync_stages    (2)
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .bus        (bus),
    .reset_key  (reset_key),
    .clr_screen (clr_screen)
  );

  always #5 sys_clock = ~sys_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- keystroke-level model ----------------
  logic [7:0] sc_tab [47] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E
  };
  logic [7:0] lo_tab [21] = '{
    8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
    8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60
  };
  logic [7:0] hi_tab [21] = '{
    8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
    8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F, 8'h7E
  };

  logic       m_strobe = 1'b0;
  logic [6:0] m_key    = 7'h00;
  logic       m_shift = 1'b0, m_ctrl = 1'b0, m_brk = 1'b0, m_clr = 1'b0;

  task automatic model_reset();
    m_strobe = 1'b0; m_key = 7'h00;
    m_shift = 1'b0; m_ctrl = 1'b0; m_brk = 1'b0; m_clr = 1'b0;
  endtask

  task automatic model_code(input logic [7:0] code);
    logic [7:0] ch;
    ch = 8'h00;
    if (code == 8'hE0) return;
    if (code == 8'hF0) begin m_brk = 1'b1; return; end
    if (m_brk) begin
      m_brk = 1'b0;
      if (code == 8'h12 || code == 8'h59) m_shift = 1'b0;
      if (code == 8'h14) m_ctrl = 1'b0;
      if (code == 8'h05) m_clr = 1'b0;
      return;
    end
    if (code == 8'h12 || code == 8'h59) begin m_shift = 1'b1; return; end
    if (code == 8'h14) begin m_ctrl = 1'b1; return; end
    if (code == 8'h05) begin m_clr = 1'b1; return; end
    if (code == 8'h07) return;
    for (int i = 0; i < 47; i++) begin
      if (sc_tab[i] == code) begin
        if (i < 26) ch = 8'(8'h41 + i);
        else        ch = m_shift ? hi_tab[i-26] : lo_tab[i-26];
      end
    end
    case (code)
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h5F;
      8'h76: ch = 8'h1B;
      8'h29: ch = 8'h20;
      default: ;
    endcase
    if (ch == 8'h00) return;
    if (m_ctrl && ch >= 8'h41 && ch <= 8'h5A) ch = ch & 8'h1F;
    m_strobe = 1'b1;
    m_key    = ch[6:0];
  endtask

  // ---------------- per-cycle compare ----------------
  logic       check_en = 1'b0;
  logic [7:0] cmp_exp;

  initial begin
    forever begin
      @(negedge sys_clock);
      #1;
      if (check_en) begin
        cmp_exp = bus.address ? {m_strobe, 7'b0} : {m_strobe, m_key};
        check("dout_vs_model", bus.dout, cmp_exp);
        check("clr_vs_model", {7'b0, clr_screen}, {7'b0, m_clr});
        check("reset_key_idle", {7'b0, reset_key}, 8'h00);
      end
    end
  end

  int rk_count = 0;
  always @(negedge sys_clock) if (reset_key === 1'b1) rk_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge sys_clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge sys_clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    check_en = 1'b0;
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge sys_clock);
    if (!bad_par && !bad_stop) model_code(code);
    check_en = 1'b1;
  endtask

  task automatic key(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0);
  endtask

  task automatic peek(input logic addr, input logic [7:0] exp, input string name);
    @(negedge sys_clock);
    bus.address = addr;
    #1;
    check(name, bus.dout, exp);
  endtask

  task automatic read_reg(input logic addr);
    @(negedge sys_clock);
    bus.address   = addr;
    bus.cpu_clken = 1'b1;
    bus.r_en      = 1'b1;
    @(negedge sys_clock);
    bus.cpu_clken = 1'b0;
    bus.r_en      = 1'b0;
    if (!addr) m_strobe = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.cpu_clken = 1'b0;
    bus.address   = 1'b0;
    bus.r_en      = 1'b0;
    repeat (3) @(negedge sys_clock);
    #1;
    check("reset_dout0", bus.dout, 8'h00);
    check("reset_rk", {7'b0, reset_key}, 8'h00);
    check("reset_clr", {7'b0, clr_screen}, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge sys_clock);
    check_en = 1'b1;

    // 'A' then a clearing read
    key(8'h1C);
    peek(1'b0, 8'hC1, "A_kbd");
    peek(1'b1, 8'h80, "A_kbdcr");
    read_reg(1'b0);
    peek(1'b0, 8'h41, "A_read_kbd");
    peek(1'b1, 8'h00, "A_read_kbdcr");
    read_reg(1'b1);  // KBDCR read has no side effect
    peek(1'b0, 8'h41, "kbdcr_no_side_effect");

    // shift + 2 -> '@', then plain 2
    key(8'h12); key(8'h1E); key(8'hF0); key(8'h1E); key(8'hF0); key(8'h12);
    peek(1'b0, 8'hC0, "shift_2_at");
    read_reg(1'b0);
    key(8'h1E);
    peek(1'b0, 8'hB2, "plain_2");
    read_reg(1'b0);

    // ctrl+C, then ctrl release, Enter and Backspace (latest key wins)
    key(8'h14); key(8'h21);
    peek(1'b0, 8'h83, "ctrl_C");
    key(8'hF0); key(8'h14);
    key(8'h5A);
    peek(1'b0, 8'h8D, "enter");
    key(8'h66);
    peek(1'b0, 8'hDF, "backspace");
    key(8'hE0); key(8'h76);
    peek(1'b0, 8'h9B, "ext_esc");
    read_reg(1'b0);

    // corrupted frames are discarded
    send_frame(8'h1C, 1'b1, 1'b0);
    peek(1'b0, 8'h1B, "bad_parity");
    send_frame(8'h1C, 1'b0, 1'b1);
    peek(1'b0, 8'h1B, "bad_stop");

    // partial frame abandoned by timeout
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 100) @(negedge sys_clock);
    key(8'h32);
    peek(1'b0, 8'hC2, "after_timeout_B");
    read_reg(1'b0);

    // F12 reset pulse, F1 clear screen
    rk_count = 0;
    key(8'h07);
    check("f12_pulse_width", 8'(rk_count), 8'd1);
    key(8'h05);
    check("f1_held", {7'b0, clr_screen}, 8'h01);
    key(8'hF0); key(8'h05);
    check("f1_released", {7'b0, clr_screen}, 8'h00);

    // new key lands on the same edge as a clearing KBD read
    key(8'h32);
    bus.address = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(1'(8'h1C >> i));
    ps2_bit(~^8'h1C);
    check_en = 1'b0;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge sys_clock);
    ps2_clk = 1'b0;
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    #1;
    check("collide_before", bus.dout, 8'hC2);
    bus.cpu_clken = 1'b1;
    bus.r_en      = 1'b1;
    @(negedge sys_clock);
    bus.cpu_clken = 1'b0;
    bus.r_en      = 1'b0;
    #1;
    check("collide_new_key_wins", bus.dout, 8'hC1);
    repeat (HALF) @(negedge sys_clock);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge sys_clock);
    m_strobe = 1'b1;
    m_key    = 7'h41;
    check_en = 1'b1;

    // reset in the middle of a frame
    key(8'h05);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge sys_clock);
    check_en = 1'b0;
    reset    = 1'b1;
    #1;
    check("midreset_dout", bus.dout, 8'h00);
    check("midreset_clr", {7'b0, clr_screen}, 8'h00);
    check("midreset_rk", {7'b0, reset_key}, 8'h00);
    model_reset();
    ps2_data = 1'b1;
    repeat (3) @(negedge sys_clock);
    reset = 1'b0;
    repeat (HALF) @(negedge sys_clock);
    check_en = 1'b1;
    key(8'h1C);
    peek(1'b0, 8'hC1, "after_reset_A");

    repeat (4) @(negedge sys_clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
